pcs_tx_encoder: RTL and testbench

PCS_TX_ENCODER -- requirements
Module: pcs_tx_encoder

---
 rtl/pcs_tx_encoder.sv | 127 ++++++++++++
 tb/tb_pcs_tx_encoder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcs_tx_encoder.sv
// rtl/pcs_tx_encoder.sv - XGMII to 64b/66b transmit block encoder with framing state machine
module pcs_tx_encoder #(
  parameter int N_CHANNELS = 8,
  parameter int W_BYTE     = 8
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset,
  input  logic                                 i_clk_en,
  input  logic [N_CHANNELS-1:0]                i_xgmii_ctrl,
  input  logic [N_CHANNELS-1:0][W_BYTE-1:0]    i_xgmii_data,
  output logic                                 o_valid,
  output logic [1:0]                           o_header,
  output logic [63:0]                          o_block,
  output logic [15:0]                          o_err_cnt
);

  // Type 0x1E with all eight 7-bit codes set to the error code 7'h1E.
  localparam logic [63:0] E_BLOCK = 64'h3C78_F1E3_C78F_1E1E;
  localparam logic [63:0] C_IDLE  = 64'h0000_0000_0000_001E;

  typedef enum logic [2:0] {ST_INIT, ST_C, ST_D, ST_T, ST_E} state_t;

  state_t      state;
  logic        is_d, is_s, is_t, is_c, t_match, legal;
  logic [2:0]  t_k;
  logic [63:0] c_block, t_block, word_block;
  logic [1:0]  word_header;

  function automatic logic [7:0] t_type(input logic [2:0] k);
    case (k)
      3'd0:    return 8'h87;
      3'd1:    return 8'h99;
      3'd2:    return 8'hAA;
      3'd3:    return 8'hB4;
      3'd4:    return 8'hCC;
      3'd5:    return 8'hD2;
      3'd6:    return 8'hE1;
      default: return 8'hFF;
    endcase
  endfunction

  // Classify the incoming word and build the block each legal class would produce.
  always_comb begin
    is_d    = (i_xgmii_ctrl == '0);
    is_s    = (i_xgmii_ctrl == N_CHANNELS'(1)) && (i_xgmii_data[0] == 8'hFB);
    is_c    = &i_xgmii_ctrl;
    c_block = C_IDLE;
    for (int j = 0; j < N_CHANNELS; j++) begin
      if (i_xgmii_data[j] != 8'h07 && i_xgmii_data[j] != 8'hFE) is_c = 1'b0;
      c_block[8+7*j +: 7] = (i_xgmii_data[j] == 8'hFE) ? 7'h1E : 7'h00;
    end

    // A terminate in lane k needs data before it and idles after it.
    is_t    = 1'b0;
    t_k     = 3'd0;
    t_match = 1'b0;
    for (int k = 0; k < N_CHANNELS; k++) begin
      t_match = 1'b1;
      for (int j = 0; j < N_CHANNELS; j++) begin
        if (j < k) begin
          if (i_xgmii_ctrl[j]) t_match = 1'b0;
        end else if (j == k) begin
          if (!i_xgmii_ctrl[j] || i_xgmii_data[j] != 8'hFD) t_match = 1'b0;
        end else begin
          if (!i_xgmii_ctrl[j] || i_xgmii_data[j] != 8'h07) t_match = 1'b0;
        end
      end
      if (t_match) begin
        is_t = 1'b1;
        t_k  = 3'(k);
      end
    end

    t_block = {56'h0, t_type(t_k)};
    for (int j = 0; j < N_CHANNELS - 1; j++) begin
      if (j < int'(t_k)) t_block[8*(j+1) +: 8] = i_xgmii_data[j];
    end

    word_header = 2'b10;
    word_block  = c_block;
    if (is_s) begin
      word_block = {i_xgmii_data[N_CHANNELS-1:1], 8'h78};
    end else if (is_t) begin
      word_block = t_block;
    end else if (is_d) begin
      word_header = 2'b01;
      word_block  = i_xgmii_data;
    end
  end

  // Which word classes the current framing state accepts; everything else becomes an E block.
  always_comb begin
    case (state)
      ST_D:    legal = is_d | is_t;
      ST_E:    legal = is_s | is_t | is_d | is_c;
      default: legal = is_s | is_c;
    endcase
  end

  // Framing state machine with registered block outputs and saturating error counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ST_INIT;
      o_valid   <= 1'b0;
      o_header  <= 2'b10;
      o_block   <= C_IDLE;
      o_err_cnt <= 16'h0000;
    end else if (i_clk_en) begin
      o_valid <= 1'b1;
      if (legal) begin
        o_header <= word_header;
        o_block  <= word_block;
        if (is_s || is_d)  state <= ST_D;
        else if (is_t)     state <= ST_T;
        else               state <= ST_C;
      end else begin
        o_header <= 2'b10;
        o_block  <= E_BLOCK;
        state    <= ST_E;
        if (o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 16'd1;
      end
    end else begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pcs_tx_encoder.sv
// tb/tb_pcs_tx_encoder.sv - self-checking bench for pcs_tx_encoder
module tb_pcs_tx_encoder;

  logic            clk = 1'b0;
  logic            reset;
  logic            clk_en;
  logic [7:0]      ctrl;
  logic [7:0][7:0] data;
  logic            valid;
  logic [1:0]      header;
  logic [63:0]     block;
  logic [15:0]     err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pcs_tx_encoder #(.N_CHANNELS(8), .W_BYTE(8)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_clk_en     (clk_en),
    .i_xgmii_ctrl (ctrl),
    .i_xgmii_data (data),
    .o_valid      (valid),
    .o_header     (header),
    .o_block      (block),
    .o_err_cnt    (err_cnt)
  );

  localparam logic [63:0] IDLE_W = 64'h0707_0707_0707_0707;
  localparam logic [63:0] CBLK   = 64'h0000_0000_0000_001E;
  localparam logic [63:0] EBLK   = 64'h3C78_F1E3_C78F_1E1E;

  // Reference model: word classes, and states named after the class that led there.
  localparam int K_D = 0, K_S = 1, K_T = 2, K_C = 3, K_E = 4, M_INIT = 5;

  int          m_state = M_INIT;
  logic        m_valid;
  logic [1:0]  m_hdr;
  logic [63:0] m_blk;
  logic [15:0] m_err;

  function automatic int classify(input logic [7:0] c, input logic [63:0] d, output int tk);
    byte unsigned b[8];
    bit ok;
    for (int i = 0; i < 8; i++) b[i] = d[8*i +: 8];
    tk = 0;
    if (c == 8'h01 && b[0] == 8'hFB) return K_S;
    for (int k = 0; k < 8; k++) begin
      ok = 1'b1;
      for (int j = 0; j < 8; j++) begin
        if (j < k)       ok = ok && !c[j];
        else if (j == k) ok = ok && c[j] && b[j] == 8'hFD;
        else             ok = ok && c[j] && b[j] == 8'h07;
      end
      if (ok) begin
        tk = k;
        return K_T;
      end
    end
    if (c == 8'h00) return K_D;
    if (c == 8'hFF) begin
      ok = 1'b1;
      for (int j = 0; j < 8; j++) ok = ok && (b[j] == 8'h07 || b[j] == 8'hFE);
      if (ok) return K_C;
    end
    return K_E;
  endfunction

  function automatic logic [63:0] encode(input int cls, input int tk, input logic [63:0] d,
                                         output logic [1:0] hdr);
    logic [55:0] codes;
    logic [63:0] blk;
    logic [7:0]  types[8];
    types = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
    hdr   = 2'b10;
    codes = '0;
    case (cls)
      K_D: begin
        hdr = 2'b01;
        blk = d;
      end
      K_S: blk = {d[63:8], 8'h78};
      K_C: begin
        for (int j = 0; j < 8; j++)
          if (d[8*j +: 8] == 8'hFE) codes = codes | (56'(7'h1E) << (7*j));
        blk = {codes, 8'h1E};
      end
      K_T: begin
        blk = 64'(types[tk]);
        for (int j = 0; j < tk; j++) blk = blk | (64'(d[8*j +: 8]) << (8*(j+1)));
      end
      default: begin
        for (int j = 0; j < 8; j++) codes = codes | (56'(7'h1E) << (7*j));
        blk = {codes, 8'h1E};
      end
    endcase
    return blk;
  endfunction

  function automatic bit allowed(input int st, input int cls);
    case (st)
      K_D:     return cls == K_D || cls == K_T;
      K_E:     return cls != K_E;
      default: return cls == K_C || cls == K_S;
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic e, input logic [7:0] c, input logic [63:0] d);
    int cls, tk;
    if (r) begin
      m_state = M_INIT;
      m_valid = 1'b0;
      m_hdr   = 2'b10;
      m_blk   = CBLK;
      m_err   = 16'h0;
    end else if (e) begin
      m_valid = 1'b1;
      cls = classify(c, d, tk);
      if (!allowed(m_state, cls)) cls = K_E;
      m_blk   = encode(cls, tk, d, m_hdr);
      m_state = (cls == K_S) ? K_D : cls;
      if (cls == K_E && m_err != 16'hFFFF) m_err = m_err + 16'd1;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [7:0] c, input logic [63:0] d);
    reset  = r;
    clk_en = e;
    ctrl   = c;
    data   = d;
    @(posedge clk);
    #1;
    model_edge(r, e, c, d);
  endtask

  task automatic rand_word(output logic [7:0] c, output logic [63:0] d);
    int kind, k;
    kind = $urandom_range(0, 9);
    d = {$urandom, $urandom};
    c = 8'h00;
    case (kind)
      0, 1: begin
        c = 8'hFF;
        for (int j = 0; j < 8; j++) d[8*j +: 8] = ($urandom_range(0, 5) == 0) ? 8'hFE : 8'h07;
      end
      2: begin
        c = 8'h01;
        d[7:0] = 8'hFB;
      end
      3, 4, 5: c = 8'h00;
      6, 7: begin
        k = $urandom_range(0, 7);
        for (int j = 0; j < 8; j++) begin
          if (j == k) begin
            c[j] = 1'b1;
            d[8*j +: 8] = 8'hFD;
          end else if (j > k) begin
            c[j] = 1'b1;
            d[8*j +: 8] = 8'h07;
          end
        end
      end
      8: c = 8'($urandom);
      default: begin
        c = 8'h02;
        d[15:8] = 8'hFB;
      end
    endcase
  endtask

  typedef struct {
    string       tag;
    logic        rst;
    logic        en;
    logic [7:0]  ctrl;
    logic [63:0] data;
    logic        v;
    logic [1:0]  hdr;
    logic [63:0] blk;
    logic [15:0] err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [7:0]  rc;
    logic [63:0] rd;
    logic        rr, re;

    reset  = 1'b1;
    clk_en = 1'b0;
    ctrl   = 8'h00;
    data   = '0;

    vecs.push_back('{"reset",       1, 1, 8'hFF, IDLE_W, 0, 2'b10, CBLK, 16'd0});
    vecs.push_back('{"idle0",       0, 1, 8'hFF, IDLE_W, 1, 2'b10, CBLK, 16'd0});
    vecs.push_back('{"idle1",       0, 1, 8'hFF, IDLE_W, 1, 2'b10, CBLK, 16'd0});
    vecs.push_back('{"idle2",       0, 1, 8'hFF, IDLE_W, 1, 2'b10, CBLK, 16'd0});
    vecs.push_back('{"frame_s",     0, 1, 8'h01, 64'h5555_5555_5555_55FB, 1, 2'b10, 64'h5555_5555_5555_5578, 16'd0});
    vecs.push_back('{"frame_d",     0, 1, 8'h00, 64'h8877_6655_4433_2211, 1, 2'b01, 64'h8877_6655_4433_2211, 16'd0});
    vecs.push_back('{"frame_t3",    0, 1, 8'hF8, 64'h0707_0707_FDCC_BBAA, 1, 2'b10, 64'h0000_0000_CCBB_AAB4, 16'd0});
    vecs.push_back('{"reset2",      1, 1, 8'h00, 64'h8877_6655_4433_2211, 0, 2'b10, CBLK, 16'd0});
    vecs.push_back('{"d_post_rst",  0, 1, 8'h00, 64'h8877_6655_4433_2211, 1, 2'b10, EBLK, 16'd1});
    vecs.push_back('{"idle_post_e", 0, 1, 8'hFF, IDLE_W, 1, 2'b10, CBLK, 16'd1});
    vecs.push_back('{"stall_s",     0, 1, 8'h01, 64'h5555_5555_5555_55FB, 1, 2'b10, 64'h5555_5555_5555_5578, 16'd1});
    vecs.push_back('{"stall_d",     0, 1, 8'h00, 64'h8877_6655_4433_2211, 1, 2'b01, 64'h8877_6655_4433_2211, 16'd1});
    for (int i = 0; i < 4; i++)
      vecs.push_back('{"stall_hold", 0, 0, 8'h01, 64'h0, 0, 2'b01, 64'h8877_6655_4433_2211, 16'd1});
    vecs.push_back('{"resume_d",    0, 1, 8'h00, 64'hA8A7_A6A5_A4A3_A2A1, 1, 2'b01, 64'hA8A7_A6A5_A4A3_A2A1, 16'd1});
    vecs.push_back('{"resume_t7",   0, 1, 8'h80, 64'hFD07_0605_0403_0201, 1, 2'b10, 64'h0706_0504_0302_01FF, 16'd1});
    vecs.push_back('{"t_in_t",      0, 1, 8'hF8, 64'h0707_0707_FDCC_BBAA, 1, 2'b10, EBLK, 16'd2});
    vecs.push_back('{"idle_end",    0, 1, 8'hFF, IDLE_W, 1, 2'b10, CBLK, 16'd2});
    vecs.push_back('{"t0_in_c",     0, 1, 8'hFF, 64'h0707_0707_0707_07FD, 1, 2'b10, EBLK, 16'd3});
    vecs.push_back('{"s_in_lane1",  0, 1, 8'h02, 64'h0000_0000_0000_FB00, 1, 2'b10, EBLK, 16'd4});
    vecs.push_back('{"c_err_lane2", 0, 1, 8'hFF, 64'h0707_0707_07FE_0707, 1, 2'b10, 64'h0000_0000_0780_001E, 16'd4});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].ctrl, vecs[i].data);
      chk({vecs[i].tag, ".valid"},  valid,   vecs[i].v);
      chk({vecs[i].tag, ".header"}, header,  vecs[i].hdr);
      chk({vecs[i].tag, ".block"},  block,   vecs[i].blk);
      chk({vecs[i].tag, ".err"},    err_cnt, vecs[i].err);
    end

    // Error counter saturation, then reset mid-run.
    step(1'b1, 1'b1, 8'h01, 64'h0);
    chk("sat.start", err_cnt, 16'd0);
    for (int i = 1; i <= 70000; i++) begin
      step(1'b0, 1'b1, 8'h01, 64'h0);
      if (i == 65534) chk("sat.before", err_cnt, 16'd65534);
      if (i == 65535) chk("sat.reach",  err_cnt, 16'hFFFF);
    end
    chk("sat.hold",  err_cnt, 16'hFFFF);
    chk("sat.block", block,   EBLK);
    step(1'b1, 1'b1, 8'h01, 64'h0);
    chk("sat.rst_err",   err_cnt, 16'd0);
    chk("sat.rst_valid", valid,   1'b0);
    step(1'b0, 1'b1, 8'h00, 64'h1122_3344_5566_7788);
    chk("sat.init_d_block", block,   EBLK);
    chk("sat.init_d_err",   err_cnt, 16'd1);

    // Randomized words against the reference model.
    step(1'b1, 1'b1, 8'hFF, IDLE_W);
    for (int i = 0; i < 3000; i++) begin
      rand_word(rc, rd);
      rr = ($urandom_range(0, 99) == 0);
      re = ($urandom_range(0, 7) != 0);
      step(rr, re, rc, rd);
      chk("rnd.valid",  valid,   m_valid);
      chk("rnd.header", header,  m_hdr);
      chk("rnd.block",  block,   m_blk);
      chk("rnd.err",    err_cnt, m_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
